// File: rtl/mfp_avalon_arb_pkg.sv
// Shared types for the two-master Avalon-MM arbiter.
// FSM states, master id width and the pending-read entry.
package mfp_avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WBURST
  } arb_state_e;

  localparam int ID_W     = 1;
  localparam int BC_MAX_W = 8;

  typedef logic [ID_W-1:0] mid_t;

  typedef struct packed {
    mid_t                id;
    logic [BC_MAX_W-1:0] bc;
  } pend_t;

  // Round-robin pick: on a tie the master
  // that did not win last time goes first.
  function automatic mid_t rr_pick(
    input logic req0,
    input logic req1,
    input mid_t last
  );
    mid_t w;
    if (req0 && req1) w = ~last;
    else if (req1)    w = 1'b1;
    else              w = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/mfp_avalon_arb_tag_fifo.sv
// In-order FIFO of outstanding read commands {id, burstcount}.
// Ports: clk/rst, push+push_data, pop, head, full, empty.
module mfp_avalon_arb_tag_fifo
  import mfp_avalon_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  pend_t push_data,
  input  logic  pop,
  output pend_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pend_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mfp_avalon_mem_arbiter.sv
// Two-master round-robin Avalon-MM arbiter for the LPDDR2 port.
// Ports: m0_*/m1_* masters, s_* slave, err_orphan debug flag.
module mfp_avalon_mem_arbiter
  import mfp_avalon_arb_pkg::*;
#(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 32,
  parameter int BURST_W  = 3,
  parameter int MAX_PEND = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [BURST_W-1:0]  m0_burstcount,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [BURST_W-1:0]  m1_burstcount,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [BURST_W-1:0]  s_burstcount,
  input  logic                s_waitrequest,
  input  logic                s_readdatavalid,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic                err_orphan
);

  arb_state_e          state_q, state_d;
  mid_t                grant_q, grant_d;
  mid_t                last_q, last_d;
  logic [BURST_W-1:0]  beats_q, beats_d;
  logic [BC_MAX_W-1:0] ret_cnt_q;
  logic                err_q;

  logic                gm_read;
  logic                gm_write;
  logic [ADDR_W-1:0]   gm_address;
  logic [DATA_W-1:0]   gm_writedata;
  logic [DATA_W/8-1:0] gm_byteenable;
  logic [BURST_W-1:0]  gm_bc;
  logic                oth_write;
  logic                gm_wait;

  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  pend_t               push_data;
  pend_t               head;
  logic                read_gate;
  logic                s_accept;
  logic                rd_route;
  logic                ret_last;

  // A zero burstcount is illegal; treat it as a single beat.
  function automatic logic [BURST_W-1:0] fix_bc(
    input logic [BURST_W-1:0] b
  );
    return (b == '0) ? BURST_W'(1) : b;
  endfunction

  assign gm_read       = grant_q ? m1_read       : m0_read;
  assign gm_write      = grant_q ? m1_write      : m0_write;
  assign gm_address    = grant_q ? m1_address    : m0_address;
  assign gm_writedata  = grant_q ? m1_writedata  : m0_writedata;
  assign gm_byteenable = grant_q ? m1_byteenable : m0_byteenable;
  assign gm_bc         = fix_bc(grant_q ? m1_burstcount
                                        : m0_burstcount);
  assign oth_write     = grant_q ? m0_write : m1_write;

  assign read_gate = gm_read & fifo_full;

  always_comb begin
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_address    = gm_address;
    s_writedata  = gm_writedata;
    s_byteenable = gm_byteenable;
    s_burstcount = gm_bc;
    gm_wait      = 1'b1;
    unique case (state_q)
      CMD: begin
        s_read  = gm_read & ~fifo_full;
        s_write = gm_write;
        gm_wait = s_waitrequest | read_gate;
      end
      WBURST: begin
        s_write = gm_write;
        gm_wait = s_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_waitrequest = grant_q ? 1'b1 : gm_wait;
  assign m1_waitrequest = grant_q ? gm_wait : 1'b1;

  assign s_accept = (s_read | s_write) & ~s_waitrequest;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beats_d = beats_q;
    unique case (state_q)
      IDLE: begin
        if (m0_read | m0_write | m1_read | m1_write) begin
          grant_d = rr_pick(m0_read | m0_write,
                            m1_read | m1_write, last_q);
          last_d  = grant_d;
          state_d = CMD;
        end
      end
      CMD: begin
        if (s_accept) begin
          if (s_read) begin
            state_d = IDLE;
          end else if (gm_bc == BURST_W'(1)) begin
            state_d = IDLE;
          end else begin
            beats_d = gm_bc - 1'b1;
            state_d = WBURST;
          end
        end else if (!gm_read && !gm_write) begin
          state_d = IDLE;
        end else if (read_gate && oth_write) begin
          // Read is stuck on a full FIFO; give the
          // pending write of the other master a turn.
          state_d = IDLE;
        end
      end
      WBURST: begin
        if (s_accept) begin
          beats_d = beats_q - 1'b1;
          if (beats_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_data    = '0;
    push_data.id = grant_q;
    push_data.bc = BC_MAX_W'(gm_bc);
  end

  assign push = (state_q == CMD) & s_read & ~s_waitrequest;

  assign rd_route = s_readdatavalid & ~fifo_empty;
  assign ret_last = ((ret_cnt_q + BC_MAX_W'(1)) == head.bc);
  assign pop      = rd_route & ret_last;

  assign m0_readdatavalid = rd_route & (head.id == 1'b0);
  assign m1_readdatavalid = rd_route & (head.id == 1'b1);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign err_orphan       = err_q;

  mfp_avalon_arb_tag_fifo #(
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      beats_q   <= '0;
      ret_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      if (rd_route)
        ret_cnt_q <= ret_last ? '0 : ret_cnt_q + 1'b1;
      if (s_readdatavalid && fifo_empty)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mfp_avalon_mem_arbiter.sv
// Self-checking bench for mfp_avalon_mem_arbiter.
// Directed scenarios followed by a randomized two-master run.
module tb_mfp_avalon_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [26:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 0, m0_write = 0;
  logic        m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [2:0]  m0_burstcount = '0, m1_burstcount = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [26:0] s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic [2:0]  s_burstcount;
  logic        s_waitrequest = 0;
  logic        s_readdatavalid = 0;
  logic [31:0] s_readdata = '0;
  logic        err_orphan;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mfp_avalon_mem_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_burstcount    (m0_burstcount),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_byteenable    (m1_byteenable),
    .m1_burstcount    (m1_burstcount),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_byteenable     (s_byteenable),
    .s_burstcount     (s_burstcount),
    .s_waitrequest    (s_waitrequest),
    .s_readdatavalid  (s_readdatavalid),
    .s_readdata       (s_readdata),
    .err_orphan       (err_orphan)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge and are
  // sampled 3 ns later, well away from the edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m,
                       input logic rd,
                       input logic wr,
                       input logic [26:0] a,
                       input logic [2:0] bc,
                       input logic [31:0] wd,
                       input logic [3:0] be);
    assert (!(rd || wr) || bc != 3'd0) else begin
      n_err++;
      $error("FAIL bc_zero: observed 0 expected nonzero");
    end
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a;
      m0_burstcount = bc; m0_writedata = wd;
      m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a;
      m1_burstcount = bc; m1_writedata = wd;
      m1_byteenable = be;
    end
  endtask

  task automatic clr_all();
    drive(0, 0, 0, '0, 3'd1, '0, '0);
    drive(1, 0, 0, '0, 3'd1, '0, '0);
    s_waitrequest   = 0;
    s_readdatavalid = 0;
  endtask

  task automatic do_reset();
    nxt(); rst = 1; clr_all();
    nxt(); nxt(); rst = 0; #3;
  endtask

  // Single-beat command held until the master sees it accepted.
  task automatic issue(input int m, input logic rd,
                       input logic [26:0] a,
                       input logic [2:0] bc);
    logic acc;
    acc = 0;
    nxt();
    drive(m, rd, !rd, a, bc, 32'h0, 4'hF);
    for (int i = 0; i < 20 && !acc; i++) begin
      if (i > 0) nxt();
      #3;
      acc = (m == 0) ? ~m0_waitrequest : ~m1_waitrequest;
    end
    chk("issue_acc", acc, 1);
    nxt();
    drive(m, 0, 0, a, bc, 32'h0, 4'hF);
    #3;
  endtask

  int          exp_route [6] = '{0, 0, 1, 1, 1, 0};
  int          seq [$];
  int          exp_q [$];
  int          c0, c1, prev, alt_bad, rem1, m0pend, nb;
  int          m0acc, m1done, owner, slave_beats;
  logic        gapped, a0, a1;
  int          busy [2], rdm [2], rem [2];
  logic [26:0] ra [2];
  logic [2:0]  rbc [2];
  logic [31:0] rwd [2];
  logic [3:0]  rbe [2];
  logic [26:0] addr;

  initial begin
    // Reset state, with requests present to show masking.
    m0_read = 1; m1_write = 1; m1_burstcount = 3'd1;
    nxt(); nxt(); #3;
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    chk("rst_err", err_orphan, 0);
    nxt(); rst = 0; clr_all(); #3;

    // Single read with one-cycle arbitration latency.
    nxt();
    drive(0, 1, 0, 27'h100, 3'd1, '0, 4'hF);
    #3;
    chk("t1_idle_sread", s_read, 0);
    chk("t1_idle_wait", m0_waitrequest, 1);
    nxt(); #3;
    chk("t1_sread", s_read, 1);
    chk("t1_saddr", s_address, 27'h100);
    chk("t1_sbc", s_burstcount, 1);
    chk("t1_m0_wait", m0_waitrequest, 0);
    chk("t1_m1_wait", m1_waitrequest, 1);
    nxt(); drive(0, 0, 0, '0, 3'd1, '0, 4'hF); #3;
    nxt(); #3;
    nxt();
    s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
    #3;
    chk("t1_m0_rdv", m0_readdatavalid, 1);
    chk("t1_m1_rdv", m1_readdatavalid, 0);
    chk("t1_rdata", m0_readdata, 32'hDEADBEEF);
    nxt(); s_readdatavalid = 0; #3;
    chk("t1_rdv_off", m0_readdatavalid, 0);

    // Contention with continuous single writes.
    c0 = 0; c1 = 0; prev = -1; alt_bad = 0;
    nxt();
    drive(0, 0, 1, 27'h0A0, 3'd1, 32'hA0A0, 4'hF);
    drive(1, 0, 1, 27'h0B1, 3'd1, 32'hB1B1, 4'hF);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) nxt();
      #3;
      if (m0_write && !m0_waitrequest) begin
        c0++;
        if (prev == 0) alt_bad++;
        prev = 0;
        chk("t2_addr0", s_address, 27'h0A0);
      end
      if (m1_write && !m1_waitrequest) begin
        c1++;
        if (prev == 1) alt_bad++;
        prev = 1;
        chk("t2_addr1", s_address, 27'h0B1);
      end
    end
    nxt(); clr_all(); #3;
    chk("t2_cnt0", c0, 4);
    chk("t2_cnt1", c1, 4);
    chk("t2_alt", alt_bad, 0);

    // Write-burst lock while m0 competes.
    rem1 = 4; m0pend = 1; gapped = 0;
    seq.delete();
    for (int i = 0; i < 40 && (rem1 > 0 || m0pend != 0); i++) begin
      nxt();
      drive(1, 0, rem1 > 0 && !(rem1 == 2 && !gapped),
            27'h200, 3'd4, 32'h1000 + 32'(4 - rem1), 4'hF);
      if (rem1 == 2) gapped = 1;
      drive(0, 0, m0pend != 0 && i > 0, 27'h300,
            3'd1, 32'h3333, 4'h3);
      s_waitrequest = (i % 2) == 1;
      #3;
      a0 = m0_write & ~m0_waitrequest;
      a1 = m1_write & ~m1_waitrequest;
      chk("t3_sacc", s_write & ~s_waitrequest, a0 | a1);
      if (a1) begin
        seq.push_back(1);
        chk("t3_wd", s_writedata, 32'h1000 + 32'(4 - rem1));
        chk("t3_sbc", s_burstcount, 4);
        rem1--;
      end
      if (a0) begin
        seq.push_back(0);
        chk("t3_addr0", s_address, 27'h300);
        m0pend = 0;
      end
    end
    nxt(); clr_all(); #3;
    chk("t3_len", seq.size(), 5);
    for (int k = 0; k < seq.size() && k < 5; k++)
      chk("t3_order", seq[k], (k < 4) ? 1 : 0);

    // Interleaved read bursts and in-order return.
    issue(0, 1, 27'h010, 3'd2);
    issue(1, 1, 27'h020, 3'd3);
    issue(0, 1, 27'h030, 3'd1);
    for (int k = 0; k < 6; k++) begin
      nxt();
      s_readdatavalid = 1; s_readdata = 32'h5000 + 32'(k);
      #3;
      chk("t4_m0_rdv", m0_readdatavalid, exp_route[k] == 0);
      chk("t4_m1_rdv", m1_readdatavalid, exp_route[k] == 1);
      chk("t4_rdata", exp_route[k] == 0 ? m0_readdata
                                        : m1_readdata,
          32'h5000 + 32'(k));
    end
    nxt(); s_readdatavalid = 0; #3;

    // FIFO full: fifth read stalls, a write still goes.
    for (int i = 0; i < 4; i++) begin
      addr = 27'h040 + 27'(i);
      issue(0, 1, addr, 3'd1);
    end
    m0acc = 0; m1done = 0;
    nxt();
    drive(0, 1, 0, 27'h050, 3'd1, '0, 4'hF);
    drive(1, 0, 1, 27'h060, 3'd1, 32'h6060, 4'hF);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nxt();
      if (m1done != 0) drive(1, 0, 0, '0, 3'd1, '0, 4'hF);
      #3;
      if (!m0_waitrequest) m0acc++;
      chk("t5_sread_gated", s_read, 0);
      if (m1_write && !m1_waitrequest) begin
        m1done = 1;
        chk("t5_waddr", s_address, 27'h060);
      end
    end
    chk("t5_m0_stalled", m0acc, 0);
    chk("t5_m1_done", m1done, 1);
    nxt(); s_readdatavalid = 1; s_readdata = 32'h4040; #3;
    chk("t5_pop_rdv", m0_readdatavalid, 1);
    chk("t5_pop_wait", m0_waitrequest, 1);
    nxt(); s_readdatavalid = 0; #3;
    chk("t5_issue_sread", s_read, 1);
    chk("t5_issue_addr", s_address, 27'h050);
    chk("t5_issue_wait", m0_waitrequest, 0);
    nxt(); drive(0, 0, 0, '0, 3'd1, '0, 4'hF); #3;
    for (int k = 0; k < 4; k++) begin
      nxt(); s_readdatavalid = 1; #3;
      chk("t5_drain_m0", m0_readdatavalid, 1);
      chk("t5_drain_m1", m1_readdatavalid, 0);
    end

    // Orphan beat on an empty FIFO.
    #0;
    nxt(); s_readdatavalid = 1; #3;
    chk("t6_orph_m0", m0_readdatavalid, 0);
    chk("t6_orph_m1", m1_readdatavalid, 0);
    nxt(); s_readdatavalid = 0; #3;
    chk("t6_err", err_orphan, 1);

    // Reset in the middle of a write burst.
    issue(0, 1, 27'h070, 3'd2);
    nb = 0;
    nxt();
    drive(1, 0, 1, 27'h400, 3'd4, 32'h4000, 4'hF);
    for (int i = 0; i < 10 && nb < 2; i++) begin
      if (i > 0) nxt();
      #3;
      if (m1_write && !m1_waitrequest) nb++;
    end
    chk("t7_beats", nb, 2);
    nxt(); rst = 1; #3;
    nxt(); rst = 0; #3;
    chk("t7_swrite", s_write, 0);
    chk("t7_m0_wait", m0_waitrequest, 1);
    chk("t7_m1_wait", m1_waitrequest, 1);
    chk("t7_err", err_orphan, 0);
    nxt();
    drive(1, 0, 0, '0, 3'd1, '0, 4'hF);
    s_readdatavalid = 1;
    #3;
    chk("t7_empty_m0", m0_readdatavalid, 0);
    chk("t7_empty_m1", m1_readdatavalid, 0);
    nxt(); s_readdatavalid = 0; #3;

    // Randomized traffic against an in-order ownership model.
    do_reset();
    slave_beats = 0;
    exp_q.delete();
    for (int m = 0; m < 2; m++) busy[m] = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n >= 1500 && busy[0] == 0 && busy[1] == 0
          && slave_beats == 0) break;
      nxt();
      for (int m = 0; m < 2; m++) begin
        if (busy[m] == 0 && n < 1500
            && $urandom_range(0, 3) == 0) begin
          busy[m] = 1;
          rdm[m]  = int'($urandom_range(0, 1));
          ra[m]   = 27'($urandom);
          rbc[m]  = 3'($urandom_range(1, 7));
          rem[m]  = int'(rbc[m]);
        end
        rwd[m] = $urandom;
        rbe[m] = 4'($urandom);
        drive(m, busy[m] != 0 && rdm[m] != 0,
              busy[m] != 0 && rdm[m] == 0
                && $urandom_range(0, 4) != 0,
              ra[m], rbc[m], rwd[m], rbe[m]);
      end
      s_waitrequest   = $urandom_range(0, 2) == 0;
      s_readdatavalid = slave_beats > 0
                        && $urandom_range(0, 1) == 1;
      s_readdata      = $urandom;
      #3;
      a0 = (m0_read | m0_write) & ~m0_waitrequest;
      a1 = (m1_read | m1_write) & ~m1_waitrequest;
      chk("r_acc", (s_read | s_write) & ~s_waitrequest,
          a0 | a1);
      chk("r_excl", a0 & a1, 0);
      for (int m = 0; m < 2; m++) begin
        if ((m == 0) ? a0 : a1) begin
          chk("r_addr", s_address, ra[m]);
          chk("r_bc", s_burstcount, rbc[m]);
          if (rdm[m] != 0) begin
            chk("r_rd", s_read, 1);
            for (int b = 0; b < int'(rbc[m]); b++)
              exp_q.push_back(m);
            busy[m] = 0;
          end else begin
            chk("r_wd", s_writedata, rwd[m]);
            chk("r_be", s_byteenable, rbe[m]);
            rem[m]--;
            if (rem[m] == 0) busy[m] = 0;
          end
        end
      end
      if (s_read && !s_waitrequest)
        slave_beats += int'(s_burstcount);
      if (s_readdatavalid) begin
        owner = (exp_q.size() > 0) ? exp_q.pop_front() : 2;
        chk("r_owner_known", owner != 2, 1);
        chk("r_m0_rdv", m0_readdatavalid, owner == 0);
        chk("r_m1_rdv", m1_readdatavalid, owner == 1);
        chk("r_rdata", owner == 1 ? m1_readdata
                                  : m0_readdata, s_readdata);
        slave_beats--;
      end else begin
        chk("r_idle_rdv",
            {m1_readdatavalid, m0_readdatavalid}, 0);
      end
    end
    chk("r_exp_drained", exp_q.size(), 0);
    chk("r_slave_drained", slave_beats, 0);
    chk("r_busy", busy[0] + busy[1], 0);
    chk("r_err", err_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mfp_avalon_mem_arbiter.md
# mfp_avalon_mem_arbiter

Two-master to one-slave Avalon-MM arbiter in front of the LPDDR2 controller port (`lpddr2_mm`). It shares the single memory port between the CPU's AHB-to-Avalon bridge (master 0) and a second bus master such as a DMA or frame reader (master 1). Arbitration is round-robin. The block tracks outstanding read bursts in order so each `readdatavalid` beat returns to the master that issued the command. It runs entirely in the memory-controller clock domain.

## Interface
Parameters:
- `ADDR_W`, 27, word address width (matches `avm_address`)
- `DATA_W`, 32, data width; byteenable is `DATA_W/8`
- `BURST_W`, 3, burstcount width; legal burst 1..`2**BURST_W-1`
- `MAX_PEND`, 4, maximum outstanding read commands (power of 2)

Ports (x = 0, 1). The clock is `clk`; reset is `rst`, synchronous and active-high.
- `clk`  in  1  memory-controller user clock (`avm_clk` at top level)
- `rst`  in  1  synchronous, active-high reset
- `mx_address`  in  `ADDR_W`  master x address
- `mx_read`, `mx_write`  in  1  master x command strobes; never both high
- `mx_writedata`  in  `DATA_W`  master x write data
- `mx_byteenable`  in  `DATA_W/8`  master x byte enables
- `mx_burstcount`  in  `BURST_W`  master x burst length, sampled on the first beat only
- `mx_waitrequest`  out  1  stall to master x
- `mx_readdata`  out  `DATA_W`  equals `s_readdata` (shared)
- `mx_readdatavalid`  out  1  read beat belongs to master x
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`, `s_burstcount`  out  slave command fields
- `s_waitrequest`, `s_readdatavalid`  in  1  slave handshake
- `s_readdata`  in  `DATA_W`  slave read data

## Operation
- **FSM states:** IDLE, CMD, WBURST.
- **IDLE:**
  - If any `mx_read|mx_write` is asserted, choose a winner and go to CMD.
  - Round-robin: the master that did not win last has priority. The `last` register resets to 1, so master 0 wins the first tie.
- **CMD:**
  - The granted master's command fields are muxed to `s_*`.
  - The granted master sees `mx_waitrequest = s_waitrequest`. The non-granted master sees waitrequest = 1.
  - A command is accepted when `s_read|s_write` is high and `s_waitrequest` is 0.
  - Read accepted: push {id, burstcount} into the pending FIFO, then return to IDLE.
  - Write accepted with burstcount 1: return to IDLE.
  - Write accepted with burstcount > 1: load `beats = burstcount-1` and go to WBURST.
- **Read gating by FIFO level:**
  - Pending FIFO full: `s_read` is forced to 0 and the granted master's waitrequest is forced to 1. Writes still proceed.
- **WBURST:**
  - The grant stays locked to the same master, and `s_burstcount` still carries the master's value.
  - Each accepted beat (`s_write & ~s_waitrequest`) decrements `beats`.
  - When `beats` goes 1→0, return to IDLE.
  - If the master deasserts `mx_write`, the FSM holds in WBURST.
- **Read return path:**
  - On `s_readdatavalid`, assert `mx_readdatavalid` for x = FIFO head id, combinationally.
  - A return-beat counter counts beats against the head burstcount. On the last beat, pop the FIFO and clear the counter.
  - A push and a pop in the same cycle are both honoured; the FIFO level is unchanged.
- **Error cases:**
  - `s_readdatavalid` with an empty FIFO: drop the beat (no `mx_readdatavalid`) and set the sticky debug flag `err_orphan`.
  - burstcount = 0 is illegal. The bench asserts against it; RTL treats it as 1.
- **Reset values:**
  - FSM = IDLE, `last` = 1, FIFO empty, counters 0, `err_orphan` = 0.
  - `s_read` = `s_write` = 0.
  - `mx_waitrequest` = 1, `mx_readdatavalid` = 0.
- **Reset mid-burst:** all tracking is discarded. The slave shares the same reset, so no in-flight beats are expected afterwards.

## Timing
- Arbitration latency: one cycle. A request asserted in cycle N, with the FSM in IDLE, reaches `s_*` in cycle N+1.
- Back-to-back commands pay one IDLE cycle each, so peak command throughput is 1 per 2 cycles for single-beat transfers. Write-burst data beats stream at 1 per cycle.
- Read-data routing adds zero latency: `mx_readdatavalid` and `mx_readdata` are combinational from `s_readdatavalid` and `s_readdata` plus the registered FIFO head.
- `s_*` command outputs are combinational from registered grant state plus master inputs; there is no combinational path from `s_waitrequest` into the FSM next-grant decision.

## Structure
- Shared package `mfp_avalon_arb_pkg`:
  - FSM state enum {IDLE, CMD, WBURST}
  - master-id width constant
  - pending-entry typedef {id, burstcount}
- Sub-module `mfp_avalon_arb_tag_fifo`: synchronous FIFO of pending entries, depth `MAX_PEND`, with full/empty flags and simultaneous push/pop support.

## Test plan
- Single reads: m0 reads burst 1 at 0x100, slave answers 2 cycles later with 0xDEADBEEF → only `m0_readdatavalid` pulses, with `m0_readdata` = 0xDEADBEEF.
- Contention: m0 and m1 both request continuously with single writes → grants alternate m0, m1, m0, m1; each master sees 4 accepts in 16 cycles.
- Write burst lock: m1 writes burst 4 with `s_waitrequest` toggling while m0 requests → all 4 beats go to the slave from m1 before m0 is granted.
- Interleaved reads: m0 burst 2, then m1 burst 3, then m0 burst 1 are accepted; slave returns 6 beats → valids route m0, m0, m1, m1, m1, m0.
- FIFO full: 4 outstanding reads with no data returned → the 5th read stalls with waitrequest = 1 while a concurrent write is still accepted; one read completes → the stalled read is issued the next cycle.
- Reset mid-WBURST after 2 of 4 beats → the next cycle shows IDLE, `s_write` = 0, both waitrequests = 1, FIFO empty.
